// File: rtl/vedic_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// vedic_mul_2x2
//   Two-bit by two-bit unsigned multiplier built the Vedic way: the vertical
//   and crosswise terms are combined with half adders. This is purely
//   combinational.
//   Ports:
//     a [1:0]  multiplicand digit
//     b [1:0]  multiplier digit
//     p [3:0]  a*b
// ---------------------------------------------------------------------------
module vedic_mul_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_hi;
  logic cross_lo;
  logic vert_hi;
  logic carry1;

  assign cross_hi = a[1] & b[0];
  assign cross_lo = a[0] & b[1];
  assign vert_hi  = a[1] & b[1];

  // Half adder on the two crosswise terms.
  assign carry1 = cross_hi & cross_lo;

  // Half adder folds that carry into the upper vertical term.
  assign p[0] = a[0] & b[0];
  assign p[1] = cross_hi ^ cross_lo;
  assign p[2] = vert_hi ^ carry1;
  assign p[3] = vert_hi & carry1;

endmodule

// ---------------------------------------------------------------------------
// vedic_mul_seq_ctrl
//   WIDTH x WIDTH unsigned multiplier that time-shares a single 2x2 Vedic
//   core. The operands are split into N = WIDTH/2 two-bit digits. One digit
//   pair is multiplied per cycle. Each partial product is shifted into place
//   and added to a 2*WIDTH-bit accumulator. An operation takes N*N CALC
//   cycles with no early exit.
//   WIDTH must be even and >= 4.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     in_valid   operand pair on a/b is valid
//     in_ready   high in IDLE only; the operands are accepted on
//                in_valid & in_ready
//     a, b       unsigned operands [WIDTH-1:0]
//     out_valid  high in DONE; product holds the final result
//     out_ready  consumer accepts the product (handshake in DONE)
//     product    accumulator value [2*WIDTH-1:0]; meaningful with out_valid
//     busy       high in CALC or DONE
// ---------------------------------------------------------------------------
module vedic_mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N  = WIDTH / 2;
  localparam int NN = N * N;
  localparam int PW = 2 * WIDTH;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [KW-1:0]    k_reg, k_next;
  // i and j track k mod N and k div N directly, so no divider is needed
  // when N is not a power of two.
  logic [IW-1:0]    i_reg, i_next;
  logic [IW-1:0]    j_reg, j_next;

  // Digit views of the captured operands.
  logic [1:0] a_dig [N];
  logic [1:0] b_dig [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digit
      assign a_dig[gi] = a_reg[2*gi+1 : 2*gi];
      assign b_dig[gi] = b_reg[2*gi+1 : 2*gi];
    end
  endgenerate

  // Shared core. It is fed straight from the digit muxes with no pipeline
  // stage, so each partial product lands in the accumulator in its own
  // cycle.
  logic [1:0] core_a;
  logic [1:0] core_b;
  logic [3:0] core_p;

  assign core_a = a_dig[i_reg];
  assign core_b = b_dig[j_reg];

  vedic_mul_2x2 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Digit pair (i, j) has weight 4^(i+j). This gives a shift of 2*(i+j).
  logic [IW:0]   digit_sum;
  logic [IW+1:0] shamt;
  logic [PW-1:0] pp_shifted;

  assign digit_sum  = {1'b0, i_reg} + {1'b0, j_reg};
  assign shamt      = {digit_sum, 1'b0};
  assign pp_shifted = PW'(core_p) << shamt;

  // Next-state and datapath logic.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    k_next     = k_reg;
    i_next     = i_reg;
    j_next     = j_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          acc_next   = '0;
          k_next     = '0;
          i_next     = '0;
          j_next     = '0;
          state_next = CALC;
        end
      end

      CALC: begin
        // The sum cannot exceed (2^WIDTH-1)^2, so no carry out is lost.
        acc_next = acc_reg + pp_shifted;
        if (k_reg == K_LAST) begin
          state_next = DONE;
        end else begin
          k_next = k_reg + KW'(1);
          if (i_reg == I_LAST) begin
            i_next = '0;
            j_next = j_reg + IW'(1);
          end else begin
            i_next = i_reg + IW'(1);
          end
        end
      end

      DONE: begin
        // Operands offered here are ignored. A new accept can only happen
        // from IDLE, one cycle later.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      k_reg     <= k_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign product   = acc_reg;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vedic_mul_seq_ctrl.
// It uses a WIDTH=8 instance and a WIDTH=4 instance.
// The reference model is plain integer multiplication of the operands.
// ---------------------------------------------------------------------------
module tb_vedic_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vedic_mul_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8)
  );

  vedic_mul_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .product   (product4),
    .busy      (busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Single operation on the selected instance (sel=1: WIDTH=4).
  // hold: cycles out_ready stays low after out_valid rises.
  // noise: keep in_valid high with other operands during CALC and DONE.
  task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input int hold, input bit noise);
    int ea, eb, lat, n;
    logic [31:0] expv;
    ea   = sel ? int'(av[3:0]) : int'(av);
    eb   = sel ? int'(bv[3:0]) : int'(bv);
    expv = 32'(ea * eb);
    lat  = sel ? 4 : 16;

    @(negedge clk);
    chk("in_ready_before_accept", sel ? in_ready4 : in_ready8, 1);
    if (sel) begin
      in_valid4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      in_valid8 = 1'b1; a8 = av; b8 = bv;
    end
    @(negedge clk);  // accept edge E0 has passed
    if (sel) begin
      in_valid4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
    end else if (noise) begin
      in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    end else begin
      in_valid8 = 1'b0;
    end
    chk("in_ready_after_accept", sel ? in_ready4 : in_ready8, 0);
    chk("busy_after_accept", sel ? busy4 : busy8, 1);

    n = 0;
    while (!(sel ? out_valid4 : out_valid8) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("product", sel ? 32'(product4) : 32'(product8), expv);
    chk("in_ready_in_done", sel ? in_ready4 : in_ready8, 0);

    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", sel ? out_valid4 : out_valid8, 1);
      chk("hold_product", sel ? 32'(product4) : 32'(product8), expv);
    end

    if (sel) out_ready4 = 1'b1; else out_ready8 = 1'b1;
    @(negedge clk);
    if (sel) out_ready4 = 1'b0; else out_ready8 = 1'b0;
    chk("out_valid_after_hs", sel ? out_valid4 : out_valid8, 0);
    chk("in_ready_after_hs", sel ? in_ready4 : in_ready8, 1);
    chk("busy_after_hs", sel ? busy4 : busy8, 0);
    chk("product_kept", sel ? 32'(product4) : 32'(product8), expv);
    if (noise) in_valid8 = 1'b0;
    $display("op w=%0d a=%0h b=%0h product=%0h lat=%0d", sel ? 4 : 8, ea, eb,
             sel ? 32'(product4) : 32'(product8), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready8", in_ready8, 1);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_product8", product8, 0);
    chk("rst_in_ready4", in_ready4, 1);
    chk("rst_product4", product4, 0);
    rst = 1'b0;

    // Directed cases.
    run_op(0, 8'hFF, 8'hFF, 0, 0);
    run_op(0, 8'h5A, 8'h3C, 5, 0);
    run_op(0, 8'h00, 8'hB7, 0, 0);
    run_op(0, 8'h01, 8'hB7, 0, 0);
    run_op(0, 8'h12, 8'h34, 2, 1);

    // Reset in cycle 7 of CALC.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hC3; b8 = 8'h9D;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_before_rst", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_calc_in_ready", in_ready8, 1);
    chk("rst_calc_out_valid", out_valid8, 0);
    chk("rst_calc_product", product8, 0);
    $display("op w=8 reset during CALC product=%0h", product8);
    run_op(0, 8'h0F, 8'h0F, 0, 0);

    // Reset while in DONE.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h77; b8 = 8'h66;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (20) @(negedge clk);
    chk("done_before_rst", out_valid8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_out_valid", out_valid8, 0);
    chk("rst_done_product", product8, 0);
    $display("op w=8 reset during DONE product=%0h", product8);

    // Random operations.
    for (int r = 0; r < 30; r++) begin
      run_op(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // WIDTH=4 instance: the corner case and then an exhaustive sweep.
    run_op(1, 8'h0F, 8'h0F, 0, 0);
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(1, 8'(x), 8'(y), 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
